// File: rtl/intersect_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : intersect_stim_sequencer
// Description : Stimulus sequencer for intersect-operator assertion benches.
//               A start in IDLE latches a configuration and drives two
//               tracks from one shared time base t:
//                 Track A   : a[*A_LEN] ##GAP b[*B_LEN]
//                 Track C/D : optional delay, C_HITS non-consecutive c
//                             pulses, then D_HITS d pulses, with the last d
//                             optionally held high for extra cycles.
//               When both tracks have finished, it pulses done and reports
//               whether the two tracks end on the same cycle (aligned).
// Ports       : clk, rst (sync, active high)
//               start, abort             - run control
//               cfg_a_len .. cfg_d_hold  - run configuration, CNT_W bits each
//               a, b, c, d               - registered stimulus outputs
//               busy                     - high on every drive cycle of a run
//               done, aligned            - completion pulse + end-cycle match
// Revision    : 1.0 - initial release
// ============================================================================
module intersect_stim_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_a_len,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_b_len,
  input  logic [CNT_W-1:0] cfg_c_hits,
  input  logic [CNT_W-1:0] cfg_d_hits,
  input  logic [CNT_W-1:0] cfg_cd_dly,
  input  logic [CNT_W-1:0] cfg_d_hold,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             aligned
);

  // Three extra bits hold the worst-case end cycle 6*(2^CNT_W - 1) plus one.
  localparam int T_W = CNT_W + 3;
  localparam logic [T_W-1:0] T_ZERO = '0;
  localparam logic [T_W-1:0] T_ONE  = T_W'(1);
  localparam logic [T_W-1:0] T_TWO  = T_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------

  // Counts that must be at least one: zero is treated as one.
  function automatic logic [T_W-1:0] clamp1(input logic [CNT_W-1:0] v);
    logic [T_W-1:0] ext;
    ext    = {{(T_W-CNT_W){1'b0}}, v};
    clamp1 = (v == '0) ? T_ONE : ext;
  endfunction

  function automatic logic [T_W-1:0] zext(input logic [CNT_W-1:0] v);
    zext = {{(T_W-CNT_W){1'b0}}, v};
  endfunction

  // Last cycle on which b is high.
  function automatic logic [T_W-1:0] calc_end_a(
    input logic [T_W-1:0] al,
    input logic [T_W-1:0] g,
    input logic [T_W-1:0] bl
  );
    calc_end_a = al + g + bl - T_TWO;
  endfunction

  // Last cycle on which d is high, hold cycles included.
  function automatic logic [T_W-1:0] calc_end_cd(
    input logic [T_W-1:0] dly,
    input logic [T_W-1:0] ch,
    input logic [T_W-1:0] dh,
    input logic [T_W-1:0] hold
  );
    calc_end_cd = dly + (ch << 1) + ((dh - T_ONE) << 1) + hold;
  endfunction

  // Stimulus value {a,b,c,d} at time t. All lower bounds are at least one
  // except for a, so no subtraction below can underflow with clamped counts.
  function automatic logic [3:0] stim_at(
    input logic [T_W-1:0] t,
    input logic [T_W-1:0] al,
    input logic [T_W-1:0] g,
    input logic [T_W-1:0] bl,
    input logic [T_W-1:0] dly,
    input logic [T_W-1:0] ch,
    input logic [T_W-1:0] dh,
    input logic [T_W-1:0] hold
  );
    logic           sa;
    logic           sb;
    logic           sc;
    logic           sd;
    logic           odd_rel;
    logic [T_W-1:0] b_lo;
    logic [T_W-1:0] b_hi;
    logic [T_W-1:0] c_lo;
    logic [T_W-1:0] c_hi;
    logic [T_W-1:0] d_lo;
    logic [T_W-1:0] d_last;
    b_lo    = al + g - T_ONE;
    b_hi    = al + g + bl - T_TWO;
    c_lo    = dly + T_ONE;
    c_hi    = dly + (ch << 1) - T_ONE;
    d_lo    = dly + (ch << 1);
    d_last  = d_lo + ((dh - T_ONE) << 1);
    // Parity of (t - dly): c pulses sit on odd offsets, d pulses on even ones.
    odd_rel = t[0] ^ dly[0];
    sa      = (t < al);
    sb      = (t >= b_lo) && (t <= b_hi);
    sc      = (t >= c_lo) && (t <= c_hi) && odd_rel;
    sd      = ((t >= d_lo) && (t <= d_last) && !odd_rel) ||
              ((t > d_last) && (t <= d_last + hold));
    stim_at = {sa, sb, sc, sd};
  endfunction

  // --------------------------------------------------------------------------
  // Configuration as seen on the inputs (used only on the start cycle)
  // --------------------------------------------------------------------------
  logic [T_W-1:0] in_a_len;
  logic [T_W-1:0] in_gap;
  logic [T_W-1:0] in_b_len;
  logic [T_W-1:0] in_c_hits;
  logic [T_W-1:0] in_d_hits;
  logic [T_W-1:0] in_cd_dly;
  logic [T_W-1:0] in_d_hold;
  logic [T_W-1:0] in_end_a;
  logic [T_W-1:0] in_end_cd;
  logic [T_W-1:0] in_end_max;

  assign in_a_len   = clamp1(cfg_a_len);
  assign in_gap     = clamp1(cfg_gap);
  assign in_b_len   = clamp1(cfg_b_len);
  assign in_c_hits  = clamp1(cfg_c_hits);
  assign in_d_hits  = clamp1(cfg_d_hits);
  assign in_cd_dly  = zext(cfg_cd_dly);
  assign in_d_hold  = zext(cfg_d_hold);
  assign in_end_a   = calc_end_a(in_a_len, in_gap, in_b_len);
  assign in_end_cd  = calc_end_cd(in_cd_dly, in_c_hits, in_d_hits, in_d_hold);
  assign in_end_max = (in_end_a > in_end_cd) ? in_end_a : in_end_cd;

  // --------------------------------------------------------------------------
  // Latched configuration and time base
  // --------------------------------------------------------------------------
  state_t         state;
  logic [T_W-1:0] t;
  logic [T_W-1:0] a_len;
  logic [T_W-1:0] gap;
  logic [T_W-1:0] b_len;
  logic [T_W-1:0] c_hits;
  logic [T_W-1:0] d_hits;
  logic [T_W-1:0] cd_dly;
  logic [T_W-1:0] d_hold;
  logic [T_W-1:0] stop_t;    // END + 1: the cycle that shows done
  logic           ends_match;

  logic [T_W-1:0] t_next;
  logic [3:0]     stim_next;
  logic [3:0]     stim_first;

  assign t_next     = t + T_ONE;
  assign stim_next  = stim_at(t_next, a_len, gap, b_len, cd_dly, c_hits,
                              d_hits, d_hold);
  assign stim_first = stim_at(T_ZERO, in_a_len, in_gap, in_b_len, in_cd_dly,
                              in_c_hits, in_d_hits, in_d_hold);

  // --------------------------------------------------------------------------
  // Sequencer FSM; every output is registered here.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      t          <= '0;
      a_len      <= '0;
      gap        <= '0;
      b_len      <= '0;
      c_hits     <= '0;
      d_hits     <= '0;
      cd_dly     <= '0;
      d_hold     <= '0;
      stop_t     <= '0;
      ends_match <= 1'b0;
      {a, b, c, d} <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      aligned    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          aligned <= 1'b0;
          // abort has no meaning in IDLE, so start always wins here.
          if (start) begin
            a_len        <= in_a_len;
            gap          <= in_gap;
            b_len        <= in_b_len;
            c_hits       <= in_c_hits;
            d_hits       <= in_d_hits;
            cd_dly       <= in_cd_dly;
            d_hold       <= in_d_hold;
            stop_t       <= in_end_max + T_ONE;
            ends_match   <= (in_end_a == in_end_cd);
            t            <= '0;
            {a, b, c, d} <= stim_first;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            {a, b, c, d} <= 4'b0000;
            busy         <= 1'b0;
            t            <= '0;
            state        <= IDLE;
          end else if (t_next == stop_t) begin
            {a, b, c, d} <= 4'b0000;
            busy         <= 1'b0;
            done         <= 1'b1;
            aligned      <= ends_match;
            t            <= t_next;
            state        <= DONE;
          end else begin
            {a, b, c, d} <= stim_next;
            t            <= t_next;
          end
        end

        DONE: begin
          done    <= 1'b0;
          aligned <= 1'b0;
          t       <= '0;
          state   <= IDLE;
        end

        default: begin
          {a, b, c, d} <= 4'b0000;
          busy    <= 1'b0;
          done    <= 1'b0;
          aligned <= 1'b0;
          t       <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_intersect_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersect_stim_sequencer
// Description : Scoreboard bench for intersect_stim_sequencer. Each directed
//               run pushes its hand-computed per-cycle output vectors
//               {a,b,c,d,busy,done,aligned} into a queue; a monitor pops one
//               vector for every cycle the DUT shows busy or done, and checks
//               that all outputs are quiet on every other cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersect_stim_sequencer;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_a_len;
  logic [CNT_W-1:0] cfg_gap;
  logic [CNT_W-1:0] cfg_b_len;
  logic [CNT_W-1:0] cfg_c_hits;
  logic [CNT_W-1:0] cfg_d_hits;
  logic [CNT_W-1:0] cfg_cd_dly;
  logic [CNT_W-1:0] cfg_d_hold;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             busy;
  logic             done;
  logic             aligned;

  intersect_stim_sequencer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_a_len  (cfg_a_len),
    .cfg_gap    (cfg_gap),
    .cfg_b_len  (cfg_b_len),
    .cfg_c_hits (cfg_c_hits),
    .cfg_d_hits (cfg_d_hits),
    .cfg_cd_dly (cfg_cd_dly),
    .cfg_d_hold (cfg_d_hold),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .busy       (busy),
    .done       (done),
    .aligned    (aligned)
  );

  logic [6:0] exp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [6:0] got,
                     input logic [6:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (abcd,busy,done,aligned) at %0t",
               name, got, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] al, input logic [3:0] g,
                         input logic [3:0] bl, input logic [3:0] ch,
                         input logic [3:0] dh, input logic [3:0] dly,
                         input logic [3:0] hold);
    cfg_a_len  = al;
    cfg_gap    = g;
    cfg_b_len  = bl;
    cfg_c_hits = ch;
    cfg_d_hits = dh;
    cfg_cd_dly = dly;
    cfg_d_hold = hold;
  endtask

  // Expected vectors from hand-written bit masks (bit n = value at t=n).
  // Cycles up to last_t are queued; done_t is the done cycle.
  task automatic push_run(input logic [15:0] am, input logic [15:0] bm,
                          input logic [15:0] cm, input logic [15:0] dm,
                          input int done_t, input logic al, input int last_t);
    for (int t = 0; t <= done_t && t <= last_t; t++) begin
      if (t < done_t)
        exp_q.push_back({am[t], bm[t], cm[t], dm[t], 1'b1, 1'b0, 1'b0});
      else
        exp_q.push_back({4'b0000, 1'b0, 1'b1, al});
    end
  endtask

  // Raise start for one cycle, then scramble cfg to show it is ignored.
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    set_cfg(4'($urandom_range(15)), 4'($urandom_range(15)),
            4'($urandom_range(15)), 4'($urandom_range(15)),
            4'($urandom_range(15)), 4'($urandom_range(15)),
            4'($urandom_range(15)));
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1 || done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got %b required no activity at %0t",
                   {a, b, c, d, busy, done, aligned}, $time);
        end else begin
          chk("cycle_vector", {a, b, c, d, busy, done, aligned},
              exp_q.pop_front());
        end
      end else begin
        chk("idle_quiet", {a, b, c, d, busy, done, aligned}, 7'b0);
      end
    end
  end

  initial begin
    // 1: reset held three cycles with start raised
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    set_cfg(4'd4, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("reset_state", {a, b, c, d, busy, done, aligned}, 7'b0);
    step();
    @(negedge clk);
    chk("start_ignored_in_reset", {a, b, c, d, busy, done, aligned}, 7'b0);
    step();
    mon_en = 1'b1;

    // 2: basic aligned run
    set_cfg(4'd4, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0);
    push_run(16'h000F, 16'h0060, 16'h000A, 16'h0050, 7, 1'b1, 99);
    launch();
    repeat (8) step();

    // 3: last d held one extra cycle
    set_cfg(4'd4, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd1);
    push_run(16'h000F, 16'h0060, 16'h000A, 16'h00D0, 8, 1'b0, 99);
    launch();
    repeat (9) step();

    // 4: C/D track delayed by one
    set_cfg(4'd4, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0);
    push_run(16'h000F, 16'h0060, 16'h0014, 16'h00A0, 8, 1'b0, 99);
    launch();
    repeat (9) step();

    // 5: start during RUN ignored, abort at t3, restart at t5
    set_cfg(4'd4, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0);
    push_run(16'h000F, 16'h0060, 16'h000A, 16'h0050, 7, 1'b1, 3);
    launch();            // in t0
    step();              // t1
    step();              // t2
    start = 1'b1;
    step();              // t3
    start = 1'b0;
    abort = 1'b1;
    step();              // t4
    abort = 1'b0;
    step();              // t5
    set_cfg(4'd4, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd1);
    push_run(16'h000F, 16'h0060, 16'h000A, 16'h00D0, 8, 1'b0, 99);
    launch();
    repeat (9) step();

    // 6: all-zero config, with abort raised alongside start
    set_cfg(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    push_run(16'h0001, 16'h0002, 16'h0002, 16'h0004, 3, 1'b0, 99);
    abort = 1'b1;
    launch();
    abort = 1'b0;
    repeat (4) step();

    // Reset in the middle of a run: no done, back to quiet
    set_cfg(4'd4, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0);
    push_run(16'h000F, 16'h0060, 16'h000A, 16'h0050, 7, 1'b1, 1);
    launch();            // t0
    step();              // t1
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();

    // A run after the mid-run reset still works
    set_cfg(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    push_run(16'h0001, 16'h0002, 16'h0002, 16'h0004, 3, 1'b0, 99);
    launch();
    repeat (6) step();

    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: %0d expected vectors never seen, required 0",
               exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
